// File: rtl/wb_arbiter_pkg.sv
// Shared types and widths for the reorder-buffer writeback arbiter.
// wb_req_t is the per-unit result payload as seen by the execution units.
package wb_arbiter_pkg;
   localparam int unsigned DATA_WIDTH    = 32;
   localparam int unsigned ROB_DEPTH_DEF = 16;
   localparam int unsigned WB_REQ_NUM    = 4;
   localparam int unsigned EXP_CODE_W    = 4;
   localparam int unsigned ROB_W         = $clog2(ROB_DEPTH_DEF);

   typedef logic [EXP_CODE_W-1:0] exp_code_t;

   typedef struct packed {
      logic [ROB_W-1:0]      rob_id;
      logic [DATA_WIDTH-1:0] data;
      logic                  exp_;
      exp_code_t             exp_code;
      logic                  pred_miss_;
      logic                  jump_miss_;
   } wb_req_t;

   // A result that redirects the pipeline must reach the ROB ahead of plain results.
   function automatic logic is_urgent(input logic exp_n, input logic pred_miss_n,
                                      input logic jump_miss_n);
      return ~exp_n | ~pred_miss_n | ~jump_miss_n;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requesting index at or after rr_ptr, wrapping.
module rr_arbiter #(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDXW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] rr_ptr,
   output logic [NREQ-1:0] grant_c,
   output logic [IDXW-1:0] grant_idx_c,
   output logic            any_grant_c
);
   logic [IDXW-1:0] idx;

   always_comb begin
      grant_c     = '0;
      grant_idx_c = '0;
      any_grant_c = 1'b0;
      idx         = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = IDXW'((32'(rr_ptr) + k) % NREQ);
         if (!any_grant_c && req[idx]) begin
            grant_c[idx] = 1'b1;
            grant_idx_c  = idx;
            any_grant_c  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/wb_arbiter.sv
// Shares the single ROB writeback port among NREQ execution units through
// one holding slot per unit and an urgency-first round-robin grant.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter  int unsigned NREQ      = WB_REQ_NUM,
   parameter  int unsigned DATA      = DATA_WIDTH,
   parameter  int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
   localparam int unsigned ROB       = $clog2(ROB_DEPTH),
   localparam int unsigned EW        = $bits(exp_code_t)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_,
   input  logic [NREQ-1:0]  req_e_,
   input  logic [NREQ*ROB-1:0]  req_rob_id,
   input  logic [NREQ*DATA-1:0] req_data,
   input  logic [NREQ-1:0]  req_exp_,
   input  logic [NREQ*EW-1:0]   req_exp_code,
   input  logic [NREQ-1:0]  req_pred_miss_,
   input  logic [NREQ-1:0]  req_jump_miss_,
   output logic [NREQ-1:0]  req_busy,
   output logic             wb_e_,
   output logic [ROB-1:0]   wb_rob_id,
   output logic [DATA-1:0]  wb_data,
   output logic             wb_exp_,
   output exp_code_t        wb_exp_code,
   output logic             wb_pred_miss_,
   output logic             wb_jump_miss_
);
   localparam int unsigned     IDXW     = $clog2(NREQ);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

   logic [NREQ-1:0] slot_valid_q, slot_valid_d;
   logic [ROB-1:0]  slot_rob_q  [NREQ];
   logic [ROB-1:0]  slot_rob_d  [NREQ];
   logic [DATA-1:0] slot_data_q [NREQ];
   logic [DATA-1:0] slot_data_d [NREQ];
   exp_code_t       slot_code_q [NREQ];
   exp_code_t       slot_code_d [NREQ];
   logic [NREQ-1:0] slot_exp_q, slot_exp_d;
   logic [NREQ-1:0] slot_pm_q, slot_pm_d;
   logic [NREQ-1:0] slot_jm_q, slot_jm_d;
   logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;

   logic            wb_e_q, wb_e_d;
   logic [ROB-1:0]  wb_rob_q, wb_rob_d;
   logic [DATA-1:0] wb_data_q, wb_data_d;
   logic            wb_exp_q, wb_exp_d;
   exp_code_t       wb_code_q, wb_code_d;
   logic            wb_pm_q, wb_pm_d;
   logic            wb_jm_q, wb_jm_d;

   logic [NREQ-1:0] urgent_c, cand_c, grant_c;
   logic [IDXW-1:0] grant_idx_c;
   logic            any_grant_c;

   // Candidates come only from registered slot state, keeping req_* off the grant path.
   always_comb begin
      urgent_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         urgent_c[i] = slot_valid_q[i] & is_urgent(slot_exp_q[i], slot_pm_q[i], slot_jm_q[i]);
      end
      cand_c = (|urgent_c) ? urgent_c : slot_valid_q;
   end

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req         (cand_c),
      .rr_ptr      (rr_ptr_q),
      .grant_c     (grant_c),
      .grant_idx_c (grant_idx_c),
      .any_grant_c (any_grant_c)
   );

   always_comb begin
      slot_valid_d = slot_valid_q;
      slot_rob_d   = slot_rob_q;
      slot_data_d  = slot_data_q;
      slot_code_d  = slot_code_q;
      slot_exp_d   = slot_exp_q;
      slot_pm_d    = slot_pm_q;
      slot_jm_d    = slot_jm_q;
      rr_ptr_d     = rr_ptr_q;
      wb_e_d       = 1'b1;
      wb_rob_d     = wb_rob_q;
      wb_data_d    = wb_data_q;
      wb_exp_d     = wb_exp_q;
      wb_code_d    = wb_code_q;
      wb_pm_d      = wb_pm_q;
      wb_jm_d      = wb_jm_q;

      // A flush kills the in-flight grant and leaves the pointer untouched.
      if (any_grant_c && flush_) begin
         rr_ptr_d  = (grant_idx_c == LAST_IDX) ? '0 : grant_idx_c + IDXW'(1);
         wb_e_d    = 1'b0;
         wb_rob_d  = slot_rob_q[grant_idx_c];
         wb_data_d = slot_data_q[grant_idx_c];
         wb_exp_d  = slot_exp_q[grant_idx_c];
         wb_code_d = slot_code_q[grant_idx_c];
         wb_pm_d   = slot_pm_q[grant_idx_c];
         wb_jm_d   = slot_jm_q[grant_idx_c];
      end

      // A slot being granted may be refilled in the same cycle.
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_c[i]) slot_valid_d[i] = 1'b0;
         if (!req_e_[i] && (!slot_valid_q[i] || grant_c[i])) begin
            slot_valid_d[i] = 1'b1;
            slot_rob_d[i]   = req_rob_id[i*ROB +: ROB];
            slot_data_d[i]  = req_data[i*DATA +: DATA];
            slot_code_d[i]  = req_exp_code[i*EW +: EW];
            slot_exp_d[i]   = req_exp_[i];
            slot_pm_d[i]    = req_pred_miss_[i];
            slot_jm_d[i]    = req_jump_miss_[i];
         end
      end

      if (!flush_) slot_valid_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_valid_q <= '0;
         slot_rob_q   <= '{default: '0};
         slot_data_q  <= '{default: '0};
         slot_code_q  <= '{default: '0};
         slot_exp_q   <= '1;
         slot_pm_q    <= '1;
         slot_jm_q    <= '1;
         rr_ptr_q     <= '0;
         wb_e_q       <= 1'b1;
         wb_rob_q     <= '0;
         wb_data_q    <= '0;
         wb_exp_q     <= 1'b1;
         wb_code_q    <= '0;
         wb_pm_q      <= 1'b1;
         wb_jm_q      <= 1'b1;
      end else begin
         slot_valid_q <= slot_valid_d;
         slot_rob_q   <= slot_rob_d;
         slot_data_q  <= slot_data_d;
         slot_code_q  <= slot_code_d;
         slot_exp_q   <= slot_exp_d;
         slot_pm_q    <= slot_pm_d;
         slot_jm_q    <= slot_jm_d;
         rr_ptr_q     <= rr_ptr_d;
         wb_e_q       <= wb_e_d;
         wb_rob_q     <= wb_rob_d;
         wb_data_q    <= wb_data_d;
         wb_exp_q     <= wb_exp_d;
         wb_code_q    <= wb_code_d;
         wb_pm_q      <= wb_pm_d;
         wb_jm_q      <= wb_jm_d;
      end
   end

   assign req_busy      = slot_valid_q & ~grant_c;
   assign wb_e_         = wb_e_q;
   assign wb_rob_id     = wb_rob_q;
   assign wb_data       = wb_data_q;
   assign wb_exp_       = wb_exp_q;
   assign wb_exp_code   = wb_code_q;
   assign wb_pred_miss_ = wb_pm_q;
   assign wb_jump_miss_ = wb_jm_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, round-robin order,
// urgency priority, flush, back-to-back issue and reset precedence.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DATA = 32;
   localparam int unsigned ROB  = 4;
   localparam int unsigned EW   = $bits(exp_code_t);

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 flush_;
   logic [NREQ-1:0]      req_e_;
   logic [NREQ*ROB-1:0]  req_rob_id;
   logic [NREQ*DATA-1:0] req_data;
   logic [NREQ-1:0]      req_exp_;
   logic [NREQ*EW-1:0]   req_exp_code;
   logic [NREQ-1:0]      req_pred_miss_;
   logic [NREQ-1:0]      req_jump_miss_;
   logic [NREQ-1:0]      req_busy;
   logic                 wb_e_;
   logic [ROB-1:0]       wb_rob_id;
   logic [DATA-1:0]      wb_data;
   logic                 wb_exp_;
   exp_code_t            wb_exp_code;
   logic                 wb_pred_miss_;
   logic                 wb_jump_miss_;

   int n_cmp = 0;
   int n_err = 0;

   wb_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .flush_         (flush_),
      .req_e_         (req_e_),
      .req_rob_id     (req_rob_id),
      .req_data       (req_data),
      .req_exp_       (req_exp_),
      .req_exp_code   (req_exp_code),
      .req_pred_miss_ (req_pred_miss_),
      .req_jump_miss_ (req_jump_miss_),
      .req_busy       (req_busy),
      .wb_e_          (wb_e_),
      .wb_rob_id      (wb_rob_id),
      .wb_data        (wb_data),
      .wb_exp_        (wb_exp_),
      .wb_exp_code    (wb_exp_code),
      .wb_pred_miss_  (wb_pred_miss_),
      .wb_jump_miss_  (wb_jump_miss_)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_e_         = '1;
      req_rob_id     = '0;
      req_data       = '0;
      req_exp_       = '1;
      req_exp_code   = '0;
      req_pred_miss_ = '1;
      req_jump_miss_ = '1;
   endtask

   task automatic set_req(input int i, input logic [ROB-1:0] rob, input logic [DATA-1:0] data,
                          input logic exp_n, input logic [EW-1:0] code,
                          input logic pm_n, input logic jm_n);
      req_e_[i]                   = 1'b0;
      req_rob_id[i*ROB +: ROB]    = rob;
      req_data[i*DATA +: DATA]    = data;
      req_exp_[i]                 = exp_n;
      req_exp_code[i*EW +: EW]    = code;
      req_pred_miss_[i]           = pm_n;
      req_jump_miss_[i]           = jm_n;
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      flush_ = 1'b1;
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({wb_rob_id, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_} !== {4'd0, 1'b1, 4'd0, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL reset_fields: got rob=%0d exp_=%b code=%0d pm_=%b jm_=%b, want 0 1 0 1 1",
                  wb_rob_id, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_);
      end
      for (int c = 0; c < 10; c++) begin
         n_cmp++;
         if ({wb_e_, req_busy, wb_data} !== {1'b1, 4'b0000, 32'h0}) begin
            n_err++;
            $display("FAIL reset_idle c%0d: got e=%b busy=%b data=%h, want e=1 busy=0000 data=0",
                     c, wb_e_, req_busy, wb_data);
         end
         tick();
      end
   endtask

   task automatic test_single();
      do_reset();
      set_req(1, 4'd5, 32'hDEADBEEF, 1'b1, '0, 1'b1, 1'b1);
      tick();
      idle_inputs();
      n_cmp++;
      if (wb_e_ !== 1'b1 || req_busy !== 4'b0000) begin
         n_err++;
         $display("FAIL single_t1: got e=%b busy=%b, want e=1 busy=0000", wb_e_, req_busy);
      end
      tick();
      n_cmp++;
      if ({wb_e_, wb_rob_id, wb_data} !== {1'b0, 4'd5, 32'hDEADBEEF}) begin
         n_err++;
         $display("FAIL single_t2: got e=%b rob=%0d data=%h, want e=0 rob=5 data=deadbeef",
                  wb_e_, wb_rob_id, wb_data);
      end
      tick();
      n_cmp++;
      if (wb_e_ !== 1'b1) begin
         n_err++;
         $display("FAIL single_t3: got e=%b, want e=1", wb_e_);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_busy;
      logic [3:0] onehot;
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, ROB'(i), DATA'(i), 1'b1, '0, 1'b1, 1'b1);
      for (int k = 1; k <= 7; k++) begin
         tick();
         onehot   = 4'b0001 << ((k - 1) % 4);
         exp_busy = 4'b1111 ^ onehot;
         n_cmp++;
         if (req_busy !== exp_busy) begin
            n_err++;
            $display("FAIL rr_busy c%0d: got %b, want %b", k, req_busy, exp_busy);
         end
         if (k >= 2) begin
            n_cmp++;
            if (wb_e_ !== 1'b0 || wb_data !== DATA'((k - 2) % 4)) begin
               n_err++;
               $display("FAIL rr_order c%0d: got e=%b data=%0d, want e=0 data=%0d",
                        k, wb_e_, wb_data, (k - 2) % 4);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_urgency();
      int order[3] = '{3, 0, 1};
      do_reset();
      set_req(0, 4'd0, 32'h10, 1'b1, 4'd0, 1'b1, 1'b1);
      set_req(1, 4'd1, 32'h11, 1'b1, 4'd0, 1'b1, 1'b1);
      set_req(2, 4'd2, 32'h12, 1'b0, 4'd2, 1'b1, 1'b1);
      set_req(3, 4'd3, 32'h13, 1'b1, 4'd0, 1'b1, 1'b1);
      tick();
      idle_inputs();
      tick();
      n_cmp++;
      if ({wb_e_, wb_rob_id, wb_exp_, wb_exp_code} !== {1'b0, 4'd2, 1'b0, 4'd2}) begin
         n_err++;
         $display("FAIL urgent_first: got e=%b rob=%0d exp_=%b code=%0d, want e=0 rob=2 exp_=0 code=2",
                  wb_e_, wb_rob_id, wb_exp_, wb_exp_code);
      end
      for (int j = 0; j < 3; j++) begin
         tick();
         n_cmp++;
         if ({wb_e_, wb_rob_id, wb_exp_} !== {1'b0, ROB'(order[j]), 1'b1}) begin
            n_err++;
            $display("FAIL urgent_rest%0d: got e=%b rob=%0d exp_=%b, want e=0 rob=%0d exp_=1",
                     j, wb_e_, wb_rob_id, wb_exp_, order[j]);
         end
      end
      tick();
      n_cmp++;
      if (wb_e_ !== 1'b1) begin
         n_err++;
         $display("FAIL urgent_drain: got e=%b, want e=1", wb_e_);
      end

      do_reset();
      set_req(0, 4'd0, 32'h30, 1'b1, 4'd0, 1'b1, 1'b1);
      set_req(3, 4'd3, 32'h33, 1'b1, 4'd0, 1'b1, 1'b0);
      tick();
      idle_inputs();
      tick();
      n_cmp++;
      if ({wb_e_, wb_rob_id, wb_jump_miss_} !== {1'b0, 4'd3, 1'b0}) begin
         n_err++;
         $display("FAIL jump_first: got e=%b rob=%0d jm_=%b, want e=0 rob=3 jm_=0",
                  wb_e_, wb_rob_id, wb_jump_miss_);
      end
      tick();
      n_cmp++;
      if ({wb_e_, wb_rob_id, wb_jump_miss_} !== {1'b0, 4'd0, 1'b1}) begin
         n_err++;
         $display("FAIL jump_second: got e=%b rob=%0d jm_=%b, want e=0 rob=0 jm_=1",
                  wb_e_, wb_rob_id, wb_jump_miss_);
      end
   endtask

   task automatic test_flush();
      do_reset();
      set_req(0, 4'd0, 32'h20, 1'b1, '0, 1'b1, 1'b1);
      set_req(3, 4'd3, 32'h23, 1'b1, '0, 1'b1, 1'b1);
      tick();
      idle_inputs();
      n_cmp++;
      if (req_busy !== 4'b1000) begin
         n_err++;
         $display("FAIL flush_pre_busy: got %b, want 1000", req_busy);
      end
      flush_ = 1'b0;
      set_req(1, 4'd1, 32'h21, 1'b1, '0, 1'b1, 1'b1);
      tick();
      flush_ = 1'b1;
      idle_inputs();
      for (int c = 0; c < 4; c++) begin
         n_cmp++;
         if (wb_e_ !== 1'b1 || req_busy !== 4'b0000) begin
            n_err++;
            $display("FAIL flush_quiet c%0d: got e=%b busy=%b, want e=1 busy=0000", c, wb_e_, req_busy);
         end
         tick();
      end
      set_req(0, 4'd8, 32'h40, 1'b1, '0, 1'b1, 1'b1);
      set_req(1, 4'd9, 32'h41, 1'b1, '0, 1'b1, 1'b1);
      tick();
      idle_inputs();
      tick();
      n_cmp++;
      if (wb_e_ !== 1'b0 || wb_rob_id !== 4'd8) begin
         n_err++;
         $display("FAIL flush_ptr_held: got e=%b rob=%0d, want e=0 rob=8", wb_e_, wb_rob_id);
      end
      tick();
      n_cmp++;
      if (wb_e_ !== 1'b0 || wb_rob_id !== 4'd9) begin
         n_err++;
         $display("FAIL flush_ptr_next: got e=%b rob=%0d, want e=0 rob=9", wb_e_, wb_rob_id);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         n_cmp++;
         if (req_busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_busy c%0d: got %b, want 0", c, req_busy[0]);
         end
         if (c >= 2) begin
            n_cmp++;
            if (wb_e_ !== 1'b0 || wb_rob_id !== ROB'(c - 1)) begin
               n_err++;
               $display("FAIL b2b_wb c%0d: got e=%b rob=%0d, want e=0 rob=%0d", c, wb_e_, wb_rob_id, c - 1);
            end
         end
         if (c < 5) set_req(0, ROB'(c + 1), DATA'(32'h100 + c + 1), 1'b1, '0, 1'b1, 1'b1);
         else       idle_inputs();
         tick();
      end
      n_cmp++;
      if (wb_e_ !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_drain: got e=%b, want e=1", wb_e_);
      end
   endtask

   task automatic test_reset_precedence();
      for (int i = 0; i < 4; i++) set_req(i, ROB'(i + 4), DATA'(32'h500 + i), 1'b0, 4'd7, 1'b1, 1'b1);
      flush_ = 1'b0;
      reset  = 1'b1;
      tick();
      n_cmp++;
      if ({wb_e_, req_busy, wb_rob_id, wb_data, wb_exp_} !== {1'b1, 4'b0000, 4'd0, 32'h0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_prec: got e=%b busy=%b rob=%0d data=%h exp_=%b, want 1 0000 0 0 1",
                  wb_e_, req_busy, wb_rob_id, wb_data, wb_exp_);
      end
      flush_ = 1'b1;
      tick();
      n_cmp++;
      if (wb_e_ !== 1'b1 || req_busy !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_hold: got e=%b busy=%b, want e=1 busy=0000", wb_e_, req_busy);
      end
      reset = 1'b0;
      idle_inputs();
      tick();
      tick();
      n_cmp++;
      if (wb_e_ !== 1'b1) begin
         n_err++;
         $display("FAIL reset_after: got e=%b, want e=1", wb_e_);
      end
   endtask

   initial begin
      reset  = 1'b1;
      flush_ = 1'b1;
      idle_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_urgency();
      test_flush();
      test_back_to_back();
      test_reset_precedence();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single reorder-buffer writeback port (wb_e_, wb_rd.addr, wb_data, wb_exp_, wb_exp_code, wb_pred_miss_, wb_jump_miss_) among NREQ execution units (ALU, branch, mul/div, LSU).
- Each unit has a one-entry holding slot. A round-robin arbiter grants one slot per cycle. Exception and mispredict results are granted before ordinary results.
- Sits between the execution units and reorder_buffer. The integrator maps wb_rob_id into wb_rd.addr.

Parameters:
- NREQ, 4, number of requesting execution units (2..8).
- DATA, `DataWidth, result width.
- ROB_DEPTH, `RobDepth, reorder buffer entries.
- ROB, $clog2(ROB_DEPTH), ROB id width (constant, not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset. No trailing underscore because it is not active-low.
- flush_  in  1  active-low pipeline flush from commit.
- req_e_  in  NREQ  active-low per-unit result valid.
- req_rob_id  in  NREQ*ROB  per-unit ROB id; unit i uses bits [i*ROB +: ROB].
- req_data  in  NREQ*DATA  per-unit result data.
- req_exp_  in  NREQ  active-low exception flag.
- req_exp_code  in  NREQ*$bits(ExpCode_t)  exception code.
- req_pred_miss_  in  NREQ  active-low branch mispredict.
- req_jump_miss_  in  NREQ  active-low jump target miss.
- req_busy  out  NREQ  1 = slot occupied and not granted this cycle; unit must hold its result.
- wb_e_  out  1  active-low writeback valid.
- wb_rob_id  out  ROB  writeback ROB id.
- wb_data  out  DATA  writeback data.
- wb_exp_  out  1  exception.
- wb_exp_code  out  ExpCode_t  exception code.
- wb_pred_miss_  out  1  mispredict.
- wb_jump_miss_  out  1  jump miss.

Behaviour:
- **Reset** (reset=1 at posedge):
  - all slot_valid = 0; rr_ptr = 0.
  - wb_e_ = 1, wb_exp_ = 1, wb_pred_miss_ = 1, wb_jump_miss_ = 1.
  - wb_rob_id = 0, wb_data = 0, wb_exp_code = 0.
  - req_busy = 0.
  - Reset takes precedence over flush_ and over every request.
- **Slot capture:**
  - Slot i loads the request fields when req_e_[i]=0 and (slot_valid[i]=0 or grant[i]=1).
  - A request presented while req_busy[i]=1 is not captured, and the unit must hold it.
- **Urgency:** slot i is urgent when its stored exp_=0 or pred_miss_=0 or jump_miss_=0.
- **Arbitration** (combinational, from registered slot state only, so there is no path from req_* to grant):
  - cand = urgent slots if any urgent slot is valid, else all valid slots.
  - Grant goes to the first cand index at or after rr_ptr, wrapping modulo NREQ.
  - At most one grant per cycle.
- **Pointer:** on any grant, rr_ptr <= (granted index + 1) mod NREQ. With no grant, rr_ptr holds.
- **req_busy[i]** = slot_valid[i] & ~grant[i].
- **Output register:**
  - On a grant, the wb_* fields are loaded from the granted slot and wb_e_ <= 0.
  - With no grant, wb_e_ <= 1 and the other wb_* fields hold their values.
- **Latency:** request in cycle t, captured at edge t+1, granted in t+1, wb_e_=0 in cycle t+2. Minimum 2 cycles.
- **Throughput:** one writeback per cycle. A single unit can issue back-to-back because capture is allowed into a slot being granted.
- **Flush** (flush_=0 at posedge):
  - all slot_valid <= 0; wb_e_ <= 1.
  - Requests in the same cycle are discarded; rr_ptr holds.
  - req_busy = 0 from the following cycle.
- **Simultaneous capture and grant on the same slot:** the new data replaces the granted data. The granted data is already in flight to the output register.

Decomposition:
- Shared header (alongside regfile.svh/exception.svh):
  - WbReq_t packed struct {rob_id, data, exp_, exp_code, pred_miss_, jump_miss_}.
  - `WbReqNum default 4.
- Sub-module rr_arbiter (NREQ):
  - inputs: req mask, rr_ptr.
  - outputs: one-hot grant, grant index, any_grant.
  - Instantiated once, with the urgency-masked candidate vector.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, all req_e_=1 → wb_e_=1, req_busy=0, wb_data=0 for 10 cycles.
- Single request: unit 1 sends rob_id=5, data=0xDEADBEEF in cycle t → wb_e_=0, wb_rob_id=5, wb_data=0xDEADBEEF in cycle t+2 only.
- Round-robin: all 4 units request every cycle with data=i → wb sequence 0,1,2,3,0,1.
  - req_busy asserted on the 3 non-granted units each cycle.
  - Each unit's held result is written exactly once.
- Urgency: unit 2 holds data with exp_=0 (code 2) while units 0, 1 and 3 are valid and rr_ptr=0 → unit 2 is granted first (wb_exp_=0, wb_exp_code=2), then 3, 0, 1.
- Flush: slots 0 and 3 full, flush_=0 for one cycle alongside a new request from unit 1 → wb_e_=1 next cycle, no writeback of any of the three, req_busy=0.
- Back-to-back single unit: unit 0 requests on 5 consecutive cycles with ids 1..5 → wb_rob_id 1..5 on 5 consecutive cycles, req_busy[0] never 1.
